if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 16 +
 rtl/if_fetch_fifo.sv | 66 ++++++
 rtl/if_fetch.sv | 99 +++++++++
 tb/tb_if_fetch.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and the fetch buffer entry type.
// Used by the instruction fetch stage and its buffer.
package if_fetch_pkg;

  localparam int INST_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = 32'd4;
  localparam logic [INST_WIDTH-1:0] ZERO_WORD = 32'h0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Instruction buffer: sync push/pop/flush, count, full/empty.
// Head reads as all-zero whenever the buffer is empty.
module if_fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Fetch stage: PC, redirect handling and instruction buffer.
// Optional trap on misaligned jump via IF_FETCH_MISALIGN_TRAP_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  input  logic [INST_WIDTH-1:0] inst_i,
  input  logic                  jump_en_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  output logic                  if_valid_o,
  input  logic                  id_ready_i,
  output logic [INST_WIDTH-1:0] if_inst_o,
  output logic [ADDR_WIDTH-1:0] if_inst_addr_o,
  output logic                  misalign_o
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic                  fetch_hold;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  fetch_entry_t          wdata;
  fetch_entry_t          head;

  assign inst_addr_o = pc;
  assign if_valid_o  = !empty;

  // Jump beats everything: no pop, no push, buffer flushed.
  assign pop  = if_valid_o && id_ready_i && !jump_en_i;
  assign push = !jump_en_i && !fetch_hold && (!full || pop);

  assign wdata.addr = pc;
  assign wdata.inst = inst_i;

  assign if_inst_o      = head.inst;
  assign if_inst_addr_o = head.addr;

`ifdef IF_FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (jump_en_i) begin
      misalign_q <= |jump_addr_i[1:0];
    end
  end

  assign jump_target = jump_addr_i;
  assign fetch_hold  = misalign_q;
  assign misalign_o  = misalign_q;

  logic unused_bits;
  assign unused_bits = ^count;
`else
  assign jump_target = {jump_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign fetch_hold  = 1'b0;
  assign misalign_o  = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{jump_addr_i[1:0], count};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (jump_en_i) begin
      pc <= jump_target;
    end else if (push) begin
      pc <= pc + PC_STEP;
    end
  end

  if_fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (jump_en_i),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with an expected-head scoreboard.
// ROM returns its own address as the instruction word.
module tb_if_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        if_valid_o;
  logic        id_ready_i;
  logic [31:0] if_inst_o;
  logic [31:0] if_inst_addr_o;
  logic        misalign_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  assign inst_i = inst_addr_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  if_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_addr_o    (inst_addr_o),
    .inst_i         (inst_i),
    .jump_en_i      (jump_en_i),
    .jump_addr_i    (jump_addr_i),
    .if_valid_o     (if_valid_o),
    .id_ready_i     (id_ready_i),
    .if_inst_o      (if_inst_o),
    .if_inst_addr_o (if_inst_addr_o),
    .misalign_o     (misalign_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge where the first expected head is present;
  // each call step is one accepted instruction, no gaps allowed.
  task automatic expect_stream(input string tag, input int n);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk({tag, "_valid"}, {31'b0, if_valid_o}, 32'd1);
      chk({tag, "_addr"}, if_inst_addr_o, e);
      chk({tag, "_inst"}, if_inst_o, e);
    end
  endtask

  task automatic jump_to(input logic [31:0] a);
    @(negedge clk);
    jump_en_i   = 1'b1;
    jump_addr_i = a;
    @(negedge clk);
    jump_en_i   = 1'b0;
    @(negedge clk);
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    id_ready_i  = 1'b0;
    jump_en_i   = 1'b0;
    jump_addr_i = 32'h0;
    repeat (2) @(negedge clk);

    chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
    chk("rst_inst", if_inst_o, 32'h0);
    chk("rst_iaddr", if_inst_addr_o, 32'h0);
    chk("rst_mis", {31'b0, misalign_o}, 32'd0);
    chk("rst_pc", inst_addr_o, 32'h0);

    // Stream straight out of reset
    id_ready_i = 1'b1;
    rst_n      = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    @(negedge clk);
    expect_stream("boot", 3);

    // Backpressure: buffer fills to two, PC parks at 0x8
    id_ready_i = 1'b0;
    sync_reset();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("bp_head", if_inst_addr_o, 32'h0);
      chk("bp_valid", {31'b0, if_valid_o}, 32'd1);
      if (c >= 2) chk("bp_pc", inst_addr_o, 32'h8);
    end
    id_ready_i = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    expect_stream("bp_drain", 3);

    // Jump while full and ready: flush, target two cycles later
    @(negedge clk);
    id_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("jf_full_valid", {31'b0, if_valid_o}, 32'd1);
    id_ready_i  = 1'b1;
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h100;
    @(negedge clk);
    jump_en_i = 1'b0;
    chk("jf_flushed", {31'b0, if_valid_o}, 32'd0);
    chk("jf_pc", inst_addr_o, 32'h100);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    @(negedge clk);
    expect_stream("jf", 2);

    // PC wraps past the top of the address space
    jump_to(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    expect_stream("wrap", 3);

`ifdef IF_FETCH_MISALIGN_TRAP_EN
    @(negedge clk);
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h102;
    @(negedge clk);
    jump_en_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("mis_flag", {31'b0, misalign_o}, 32'd1);
      chk("mis_valid", {31'b0, if_valid_o}, 32'd0);
      @(negedge clk);
    end
    jump_to(32'h200);
    chk("mis_clear", {31'b0, misalign_o}, 32'd0);
    exp_q.push_back(32'h200);
    expect_stream("mis_recover", 1);
`else
    jump_to(32'h102);
    chk("mis_tied", {31'b0, misalign_o}, 32'd0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    expect_stream("mis_align", 2);
`endif

    // Asynchronous reset in the middle of a stream
    @(negedge clk);
    chk("ar_pre_valid", {31'b0, if_valid_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("ar_valid", {31'b0, if_valid_o}, 32'd0);
    chk("ar_iaddr", if_inst_addr_o, 32'h0);
    chk("ar_pc", inst_addr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    @(negedge clk);
    expect_stream("ar_restart", 2);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
